// File: rtl/serial_subtractor_19bit.sv
// Bit-serial ripple-borrow subtractor with valid/ready handshakes on both sides.
// Result is {borrow_out, difference}; one operand bit is consumed per cycle, LSB first.
module serial_subtractor_19bit #(
  parameter int unsigned WIDTH = 19
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_minuend,
  input  logic [WIDTH-1:0] i_subtrahend,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH:0]   o_result
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] diff_q;
  logic [CNT_W-1:0] cnt_q;
  logic             brw_q;
  logic             ready_q;
  logic             valid_q;
  logic [WIDTH:0]   result_q;

  logic [IDX_W-1:0] bit_idx;
  logic             a_bit;
  logic             b_bit;
  logic             d_bit_d;
  logic             brw_d;
  logic [WIDTH-1:0] diff_d;
  logic             last_bit;

  // One full-subtractor cell applied to the operand bit selected by the counter
  always_comb begin
    bit_idx  = cnt_q[IDX_W-1:0];
    a_bit    = a_q[bit_idx];
    b_bit    = b_q[bit_idx];
    d_bit_d  = a_bit ^ b_bit ^ brw_q;
    brw_d    = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & brw_q);
    diff_d   = diff_q;
    diff_d[bit_idx] = d_bit_d;
    last_bit = (cnt_q == CNT_W'(WIDTH - 1));
  end

  // Control FSM plus datapath registers; reset overrides every handshake
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      brw_q    <= 1'b0;
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
      result_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_valid) begin
            a_q     <= i_minuend;
            b_q     <= i_subtrahend;
            diff_q  <= '0;
            cnt_q   <= '0;
            brw_q   <= 1'b0;
            ready_q <= 1'b0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          cnt_q  <= cnt_q + CNT_W'(1);
          brw_q  <= brw_d;
          diff_q <= diff_d;
          if (last_bit) begin
            result_q <= {brw_d, diff_d};
            valid_q  <= 1'b1;
            state_q  <= DONE;
          end
        end
        DONE: begin
          if (i_ready) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: begin
          valid_q <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign o_ready  = ready_q;
  assign o_valid  = valid_q;
  assign o_result = result_q;

endmodule

// File: tb/tb_serial_subtractor_19bit.sv
// Directed and random stimulus for the serial subtractor with a result scoreboard.
module tb_serial_subtractor_19bit;

  localparam int unsigned W = 19;

  logic         i_clk = 1'b0;
  logic         i_rst;
  logic         i_valid;
  logic         o_ready;
  logic [W-1:0] i_minuend;
  logic [W-1:0] i_subtrahend;
  logic         o_valid;
  logic         i_ready;
  logic [W:0]   o_result;

  int checks   = 0;
  int failures = 0;
  int sent     = 0;
  int received = 0;

  logic [W:0] exp_q[$];

  serial_subtractor_19bit #(.WIDTH(W)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_minuend    (i_minuend),
    .i_subtrahend (i_subtrahend),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_result     (o_result)
  );

  always #5 i_clk = ~i_clk;

  // Reference: low bits are the modular difference, top bit flags A < B
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] d;
    d = a - b;
    return {(a < b), d};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one operation from a negedge and retire it; returns at a negedge with the DUT idle
  task automatic send_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input int gap, input int hold, input bit noise);
    int         n;
    int         lat;
    logic [W:0] first;
    logic [W:0] exp;
    repeat (gap) @(negedge i_clk);
    n = 0;
    while (!o_ready && n < 100) begin
      @(negedge i_clk);
      n++;
    end
    chk("ready_before_send", 64'(o_ready), 64'd1);
    i_valid      = 1'b1;
    i_minuend    = a;
    i_subtrahend = b;
    exp_q.push_back(model(a, b));
    sent++;
    @(negedge i_clk);
    i_valid = 1'b0;
    lat = 0;
    while (!o_valid && lat < int'(W) + 5) begin
      if (noise) begin
        i_valid      = 1'($urandom);
        i_minuend    = W'($urandom);
        i_subtrahend = W'($urandom);
      end
      @(negedge i_clk);
      lat++;
    end
    i_valid = 1'b0;
    chk("latency", 64'(lat), 64'(W));
    first = o_result;
    for (int k = 0; k < hold; k++) begin
      chk("hold_valid", 64'(o_valid), 64'd1);
      chk("hold_result", 64'(o_result), 64'(first));
      @(negedge i_clk);
    end
    i_ready = 1'b1;
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
    chk("result", 64'(o_result), 64'(exp));
    received++;
    @(negedge i_clk);
    i_ready = 1'b0;
    chk("valid_after_ack", 64'(o_valid), 64'd0);
    chk("ready_after_ack", 64'(o_ready), 64'd1);
  endtask

  initial begin
    bit seen_valid;
    i_rst        = 1'b1;
    i_valid      = 1'b1;
    i_ready      = 1'b0;
    i_minuend    = W'(7);
    i_subtrahend = W'(1);
    repeat (3) @(negedge i_clk);
    i_rst   = 1'b0;
    i_valid = 1'b0;
    chk("rst_ready", 64'(o_ready), 64'd1);
    chk("rst_valid", 64'(o_valid), 64'd0);
    chk("rst_result", 64'(o_result), 64'd0);
    @(negedge i_clk);
    chk("no_capture_on_reset", 64'(o_ready), 64'd1);

    // Directed corner operands
    send_op(W'(5),       W'(3),       0, 0, 1'b0);
    send_op(W'(3),       W'(5),       0, 0, 1'b0);
    send_op(W'(0),       W'(1),       0, 0, 1'b0);
    send_op(W'('h7FFFF), W'('h7FFFF), 0, 0, 1'b0);
    send_op(W'('h7FFFF), W'(0),       0, 0, 1'b0);
    chk("const_5_3", 64'(model(W'(5), W'(3))), 64'h00002);

    // Backpressure: result held for 5 cycles
    send_op(W'(12345), W'(54321), 1, 5, 1'b0);

    // Operand noise during the shift phase must be ignored
    send_op(W'('h2AAAA), W'('h15555), 0, 0, 1'b1);

    // Reset at counter=10 discards the operation
    i_valid      = 1'b1;
    i_minuend    = W'(100);
    i_subtrahend = W'(7);
    @(negedge i_clk);
    i_valid = 1'b0;
    repeat (10) @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    chk("midrst_valid", 64'(o_valid), 64'd0);
    chk("midrst_ready", 64'(o_ready), 64'd1);
    chk("midrst_result", 64'(o_result), 64'd0);
    seen_valid = 1'b0;
    repeat (25) begin
      @(negedge i_clk);
      if (o_valid) seen_valid = 1'b1;
    end
    chk("midrst_no_valid", 64'(seen_valid), 64'd0);

    // Random traffic with random gaps and backpressure
    for (int i = 0; i < 1000; i++) begin
      send_op(W'($urandom), W'($urandom), int'($urandom_range(0, 2)),
              int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    chk("count_match", 64'(received), 64'(sent));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
